sm83_ir_sequencer: RTL

- Instruction-register and M-cycle sequencer for the SM83 core.
- Latches each fetched opcode and tracks the CB-prefix bank. Sequences interrupt entry and HALT.
- Counts M-cycles per instruction, with conditional-branch length resolution.
- Its opcode, bank_cb and intr_entry outputs feed the existing combinational decoder; m_cycle and last_cycle feed the control ROM.

---
 rtl/sm83_ir_sequencer_pkg.sv | 70 +++++++
 rtl/sm83_ir_sequencer_mcycle_len.sv | 31 +++
 rtl/sm83_ir_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/sm83_ir_sequencer_pkg.sv
// Shared opcode constants, conditional-branch kinds and the per-opcode M-cycle length lookup
// for the SM83 instruction-register sequencer.
package sm83_seq_pkg;

  localparam logic [7:0] OP_CB   = 8'hCB;
  localparam logic [7:0] OP_HALT = 8'h76;
  localparam logic [7:0] OP_NOP  = 8'h00;

  typedef enum logic [2:0] {CC_NONE, CC_JR, CC_JP, CC_CALL, CC_RET} cc_kind_t;

  typedef struct packed {
    logic [2:0] len_taken;
    logic [2:0] len_not;
    cc_kind_t   cc;
  } len_info_t;

  // Opcode split as x=[7:6], y=[5:3], z=[2:0]; CB-bank lengths exclude the prefix cycle.
  function automatic len_info_t len_lookup(input logic [7:0] op, input logic cb);
    logic [1:0] x;
    logic [2:0] y, z, t, n;
    cc_kind_t   c;
    len_info_t  r;
    x = op[7:6];
    y = op[5:3];
    z = op[2:0];
    t = 3'd1;
    n = 3'd1;
    c = CC_NONE;
    if (cb) begin
      if (z == 3'd6) t = (x == 2'd1) ? 3'd2 : 3'd3;
    end else begin
      case (x)
        2'd0: case (z)
          3'd0: if (y == 3'd1) t = 3'd5;
                else if (y == 3'd3) t = 3'd3;
                else if (y[2]) begin t = 3'd3; n = 3'd2; c = CC_JR; end
          3'd1: t = y[0] ? 3'd2 : 3'd3;
          3'd2, 3'd3: t = 3'd2;
          3'd4, 3'd5: if (y == 3'd6) t = 3'd3;
          3'd6: t = (y == 3'd6) ? 3'd3 : 3'd2;
          default: t = 3'd1;
        endcase
        2'd1: if ((y == 3'd6) != (z == 3'd6)) t = 3'd2;
        2'd2: if (z == 3'd6) t = 3'd2;
        default: case (z)
          3'd0: if (!y[2]) begin t = 3'd5; n = 3'd2; c = CC_RET; end
                else if (y == 3'd5) t = 3'd4;
                else t = 3'd3;
          3'd1: if (!y[0]) t = 3'd3;
                else if (!y[2]) t = 3'd4;
                else if (y == 3'd7) t = 3'd2;
          3'd2: if (!y[2]) begin t = 3'd4; n = 3'd3; c = CC_JP; end
                else t = y[0] ? 3'd4 : 3'd2;
          3'd3: if (y == 3'd0) t = 3'd4;
          3'd4: if (!y[2]) begin t = 3'd6; n = 3'd3; c = CC_CALL; end
          3'd5: if (!y[0]) t = 3'd4;
                else if (y == 3'd1) t = 3'd6;
          3'd6: t = 3'd2;
          default: t = 3'd4;
        endcase
      endcase
    end
    if (c == CC_NONE) n = t;
    r.len_taken = t;
    r.len_not   = n;
    r.cc        = c;
    return r;
  endfunction

endpackage

// File: rtl/sm83_ir_sequencer_mcycle_len.sv
// Combinational instruction-length resolver: taken / not-taken M-cycle counts and branch kind,
// with interrupt entry overriding the opcode lookup.
module sm83_mcycle_len
  import sm83_seq_pkg::*;
#(
  parameter int MCYC_W      = 3,
  parameter int INTR_CYCLES = 5
) (
  input  logic [7:0]      opcode,
  input  logic            bank_cb,
  input  logic            intr_entry,
  output logic [MCYC_W:0] len_taken,
  output logic [MCYC_W:0] len_not,
  output cc_kind_t        cc_kind
);
  localparam int LW = MCYC_W + 1;

  len_info_t info;
  assign info = len_lookup(opcode, bank_cb);

  always_comb begin
    len_taken = LW'(info.len_taken);
    len_not   = LW'(info.len_not);
    cc_kind   = info.cc;
    if (intr_entry) begin
      len_taken = LW'(INTR_CYCLES);
      len_not   = LW'(INTR_CYCLES);
      cc_kind   = CC_NONE;
    end
  end
endmodule

// File: rtl/sm83_ir_sequencer.sv
// SM83 instruction register and M-cycle sequencer: IR/CB-bank latch, HALT, interrupt entry,
// and per-instruction M-cycle counting with conditional-branch length resolution.
module sm83_ir_sequencer
  import sm83_seq_pkg::*;
#(
  parameter int         MCYC_W       = 3,
  parameter logic [7:0] RESET_OPCODE = OP_NOP,
  parameter int         INTR_CYCLES  = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [7:0]        data_in,
  input  logic              cond_met,
  input  logic              intr_req,
  input  logic              ime,
  output logic [7:0]        opcode,
  output logic              bank_cb,
  output logic              intr_entry,
  output logic [MCYC_W-1:0] m_cycle,
  output logic              last_cycle,
  output logic              halted
);
  localparam int LW = MCYC_W + 1;

  if (MCYC_W < 3) begin : g_bad_mcyc_w
    $error("sm83_ir_sequencer: MCYC_W must be >= 3");
  end
  if (INTR_CYCLES < 2 || INTR_CYCLES > (1 << MCYC_W)) begin : g_bad_intr_cycles
    $error("sm83_ir_sequencer: INTR_CYCLES out of range");
  end

  logic [MCYC_W:0] len_taken, len_not, dec_cyc, mc_ext;
  cc_kind_t        cc_kind;

  sm83_mcycle_len #(.MCYC_W(MCYC_W), .INTR_CYCLES(INTR_CYCLES)) u_len (
    .opcode    (opcode),
    .bank_cb   (bank_cb),
    .intr_entry(intr_entry),
    .len_taken (len_taken),
    .len_not   (len_not),
    .cc_kind   (cc_kind)
  );

  assign mc_ext = {1'b0, m_cycle};

  // Cycle where cond_met picks the path; the not-taken path ends right there.
  always_comb begin
    case (cc_kind)
      CC_JR, CC_JP: dec_cyc = len_not - 1'b1;
      CC_CALL:      dec_cyc = LW'(2);
      CC_RET:       dec_cyc = LW'(1);
      default:      dec_cyc = '1;
    endcase
  end

  always_comb begin
    last_cycle = 1'b0;
    if (halted)
      last_cycle = 1'b0;
    else if (cc_kind != CC_NONE && mc_ext == dec_cyc)
      last_cycle = !cond_met;
    else
      last_cycle = (mc_ext == len_taken - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      opcode     <= RESET_OPCODE;
      bank_cb    <= 1'b0;
      intr_entry <= 1'b0;
      m_cycle    <= '0;
      halted     <= 1'b0;
    end else if (ce) begin
      if (halted) begin
        if (intr_req) begin
          halted <= 1'b0;
          if (ime) intr_entry <= 1'b1;
          else begin
            opcode  <= data_in;
            bank_cb <= 1'b0;
          end
        end
      end else if (!last_cycle) begin
        m_cycle <= m_cycle + 1'b1;
      end else begin
        m_cycle <= '0;
        if (intr_entry) begin
          intr_entry <= 1'b0;
          opcode     <= data_in;
          bank_cb    <= 1'b0;
        end else if (!bank_cb && opcode == OP_CB) begin
          opcode  <= data_in;
          bank_cb <= 1'b1;
        end else if (!bank_cb && opcode == OP_HALT && !intr_req) begin
          halted <= 1'b1;
        end else if (intr_req && ime) begin
          intr_entry <= 1'b1;
          bank_cb    <= 1'b0;
        end else begin
          opcode  <= data_in;
          bank_cb <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n)
      assert (!(m_cycle == '1 && !last_cycle))
        else $error("sm83_ir_sequencer: m_cycle at maximum without last_cycle");
  end
endmodule
